// File: rtl/rob_commit_if.sv
// Bundle between the reorder buffer and its neighbours: ID allocation, CDB writeback,
// operand lookups and the architectural register-file write port.
interface rob_commit_if #(
  parameter int IDW = 5
);
  logic           alloc_en;
  logic [4:0]     alloc_rd;
  logic           alloc_has_rd;
  logic [IDW-1:0] alloc_id;
  logic           full;

  logic           cdb_en;
  logic [IDW-1:0] cdb_id;
  logic [31:0]    cdb_data;
  logic           cdb_mispred;
  logic [31:0]    cdb_pc;

  logic [IDW-1:0] qid1;
  logic           qrdy1;
  logic [31:0]    qdata1;
  logic [IDW-1:0] qid2;
  logic           qrdy2;
  logic [31:0]    qdata2;

  logic           we;
  logic [4:0]     waddr;
  logic [IDW-1:0] wid;
  logic [31:0]    wdata;
  logic           rst_c;
  logic [31:0]    flush_pc;

  modport master (
    output alloc_en, alloc_rd, alloc_has_rd,
    output cdb_en, cdb_id, cdb_data, cdb_mispred, cdb_pc,
    output qid1, qid2,
    input  alloc_id, full,
    input  qrdy1, qdata1, qrdy2, qdata2,
    input  we, waddr, wid, wdata, rst_c, flush_pc
  );

  modport slave (
    input  alloc_en, alloc_rd, alloc_has_rd,
    input  cdb_en, cdb_id, cdb_data, cdb_mispred, cdb_pc,
    input  qid1, qid2,
    output alloc_id, full,
    output qrdy1, qdata1, qrdy2, qdata2,
    output we, waddr, wid, wdata, rst_c, flush_pc
  );
endinterface

// File: rtl/rob_commit.sv
// Reorder buffer: in-order allocation from ID, out-of-order CDB completion,
// in-order single-entry retirement to the register file, flush on mispredicted head.
module rob_commit #(
  parameter int DEPTH = 16,
  parameter int IDW   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  rob_commit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Control state (async reset)
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] ready_q;
  logic [AW-1:0]    head_q;
  logic [AW-1:0]    tail_q;
  logic [CW-1:0]    count_q;

  // Payload (no reset; only meaningful while the entry is valid)
  logic [4:0]       rd_q [DEPTH];
  logic [DEPTH-1:0] has_rd_q;
  logic [DEPTH-1:0] mispred_q;
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      pc_q [DEPTH];

  // Register-file write port and flush
  logic             we_q;
  logic [4:0]       waddr_q;
  logic [IDW-1:0]   wid_q;
  logic [31:0]      wdata_q;
  logic             rst_c_q;
  logic [31:0]      flush_pc_q;

  logic             full;
  logic             retire;
  logic             flush;
  logic             alloc;
  logic             wb;
  logic [AW-1:0]    cdb_idx;
  logic             cdb_inr;

  logic [AW-1:0]    q1_idx;
  logic [AW-1:0]    q2_idx;
  logic             q1_inr;
  logic             q2_inr;
  logic             fwd1;
  logic             fwd2;
  logic             qrdy1;
  logic             qrdy2;
  logic [31:0]      qdata1;
  logic [31:0]      qdata2;

  // IDs at or above DEPTH never name a live entry
  always_comb begin
    cdb_idx = bus.cdb_id[AW-1:0];
    cdb_inr = (bus.cdb_id >> AW) == '0;
    q1_idx  = bus.qid1[AW-1:0];
    q1_inr  = (bus.qid1 >> AW) == '0;
    q2_idx  = bus.qid2[AW-1:0];
    q2_inr  = (bus.qid2 >> AW) == '0;
  end

  // full uses the pre-commit count, so a same-edge retire cannot make room
  always_comb begin
    full   = count_q == DEPTH_C;
    retire = rdy && !rst_c_q && valid_q[head_q] && ready_q[head_q];
    flush  = retire && mispred_q[head_q];
    alloc  = rdy && !rst_c_q && bus.alloc_en && !full && !flush;
    wb     = rdy && !rst_c_q && bus.cdb_en && cdb_inr && valid_q[cdb_idx];
  end

  always_comb begin
    fwd1   = bus.cdb_en && (bus.cdb_id == bus.qid1);
    fwd2   = bus.cdb_en && (bus.cdb_id == bus.qid2);
    qrdy1  = 1'b0;
    qrdy2  = 1'b0;
    qdata1 = '0;
    qdata2 = '0;
    if (!rst_c_q) begin
      qrdy1  = fwd1 || (q1_inr && valid_q[q1_idx] && ready_q[q1_idx]);
      qrdy2  = fwd2 || (q2_inr && valid_q[q2_idx] && ready_q[q2_idx]);
      qdata1 = fwd1 ? bus.cdb_data : data_q[q1_idx];
      qdata2 = fwd2 ? bus.cdb_data : data_q[q2_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      rd_q[tail_q]      <= bus.alloc_rd;
      has_rd_q[tail_q]  <= bus.alloc_has_rd;
      mispred_q[tail_q] <= 1'b0;
    end
    if (wb) begin
      data_q[cdb_idx]    <= bus.cdb_data;
      mispred_q[cdb_idx] <= bus.cdb_mispred;
      pc_q[cdb_idx]      <= bus.cdb_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      ready_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wid_q      <= '0;
      wdata_q    <= '0;
      rst_c_q    <= 1'b0;
      flush_pc_q <= '0;
    end else if (rdy) begin
      rst_c_q <= flush;
      we_q    <= retire && has_rd_q[head_q];
      if (retire) begin
        waddr_q <= rd_q[head_q];
        wid_q   <= IDW'(head_q);
        wdata_q <= data_q[head_q];
      end
      if (flush) begin
        flush_pc_q <= pc_q[head_q];
        valid_q    <= '0;
        ready_q    <= '0;
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
      end else begin
        // Writeback first so a retire of the same entry clears it last
        if (wb) begin
          ready_q[cdb_idx] <= 1'b1;
        end
        if (retire) begin
          valid_q[head_q] <= 1'b0;
          ready_q[head_q] <= 1'b0;
          head_q          <= head_q + 1'b1;
        end
        if (alloc) begin
          valid_q[tail_q] <= 1'b1;
          ready_q[tail_q] <= 1'b0;
          tail_q          <= tail_q + 1'b1;
        end
        count_q <= count_q + CW'(alloc) - CW'(retire);
      end
    end
  end

  assign bus.alloc_id = IDW'(tail_q);
  assign bus.full     = full;
  assign bus.qrdy1    = qrdy1;
  assign bus.qdata1   = qdata1;
  assign bus.qrdy2    = qrdy2;
  assign bus.qdata2   = qdata2;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wid      = wid_q;
  assign bus.wdata    = wdata_q;
  assign bus.rst_c    = rst_c_q;
  assign bus.flush_pc = flush_pc_q;

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: per-cycle vector table plus hand-written
// sequences for full/wrap, stall and mid-run reset.
module tb_rob_commit;
  localparam int IDW = 5;

  logic clk;
  logic rst;
  logic rdy;

  rob_commit_if #(.IDW(IDW)) bus ();

  rob_commit #(.DEPTH(16), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           ae;
    logic [4:0]     ard;
    logic           ahr;
    logic           ce;
    logic [IDW-1:0] cid;
    logic [31:0]    cdata;
    logic           cmp;
    logic [31:0]    cpc;
    logic [IDW-1:0] qid;
    logic [IDW-1:0] e_aid;
    logic           e_full;
    logic           e_qrdy;
    logic [31:0]    e_qdata;
    logic           e_we;
    logic [4:0]     e_waddr;
    logic [31:0]    e_wdata;
    logic           e_rstc;
    logic [31:0]    e_fpc;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];
  int checks;
  int errors;

  function automatic vec_t v(int ae, int ard, int ahr, int ce, int cid, int cdata, int cmp,
                             int cpc, int qid, int aid, int full, int qrdy, int qdata,
                             int we, int waddr, int wdata, int rstc, int fpc);
    vec_t r;
    r.ae = ae[0];       r.ard = ard[4:0];     r.ahr = ahr[0];
    r.ce = ce[0];       r.cid = cid[4:0];     r.cdata = 32'(cdata);
    r.cmp = cmp[0];     r.cpc = 32'(cpc);     r.qid = qid[4:0];
    r.e_aid = aid[4:0]; r.e_full = full[0];   r.e_qrdy = qrdy[0];
    r.e_qdata = 32'(qdata);
    r.e_we = we[0];     r.e_waddr = waddr[4:0]; r.e_wdata = 32'(wdata);
    r.e_rstc = rstc[0]; r.e_fpc = 32'(fpc);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.alloc_en     = 1'b0;
    bus.alloc_rd     = '0;
    bus.alloc_has_rd = 1'b0;
    bus.cdb_en       = 1'b0;
    bus.cdb_id       = '0;
    bus.cdb_data     = '0;
    bus.cdb_mispred  = 1'b0;
    bus.cdb_pc       = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rdy = 1'b1;
    bus.qid1 = '0;
    bus.qid2 = '0;
    idle();

    //        ae ard ahr ce cid cdata   mp cpc    qid | aid full qrdy qdata  | we wa wdata rc fpc
    vecs[0]  = v(1, 3, 1, 0, 0, 0,      0, 0,     0,    0, 0, 0, 0,          0, 0, 0,     0, 0);
    vecs[1]  = v(1, 4, 1, 0, 0, 0,      0, 0,     0,    1, 0, 0, 0,          0, 0, 0,     0, 0);
    vecs[2]  = v(0, 0, 0, 1, 1, 'h22,   0, 0,     1,    2, 0, 1, 'h22,       0, 0, 0,     0, 0);
    vecs[3]  = v(0, 0, 0, 1, 0, 'h11,   0, 0,     1,    2, 0, 1, 'h22,       0, 0, 0,     0, 0);
    vecs[4]  = v(0, 0, 0, 0, 0, 0,      0, 0,     0,    2, 0, 1, 'h11,       1, 3, 'h11,  0, 0);
    vecs[5]  = v(0, 0, 0, 0, 0, 0,      0, 0,     0,    2, 0, 0, 0,          1, 4, 'h22,  0, 0);
    vecs[6]  = v(0, 0, 0, 0, 0, 0,      0, 0,     1,    2, 0, 0, 0,          0, 4, 'h22,  0, 0);
    vecs[7]  = v(1, 5, 0, 0, 0, 0,      0, 0,     1,    2, 0, 0, 0,          0, 4, 'h22,  0, 0);
    vecs[8]  = v(1, 6, 1, 0, 0, 0,      0, 0,     1,    3, 0, 0, 0,          0, 4, 'h22,  0, 0);
    vecs[9]  = v(1, 7, 1, 0, 0, 0,      0, 0,     1,    4, 0, 0, 0,          0, 4, 'h22,  0, 0);
    vecs[10] = v(1, 8, 1, 0, 0, 0,      0, 0,     1,    5, 0, 0, 0,          0, 4, 'h22,  0, 0);
    vecs[11] = v(0, 0, 0, 1, 3, 'h33,   1, 'h100, 3,    6, 0, 1, 'h33,       0, 4, 'h22,  0, 0);
    vecs[12] = v(0, 0, 0, 1, 5, 'hABCD, 0, 0,     5,    6, 0, 1, 'hABCD,     0, 4, 'h22,  0, 0);
    vecs[13] = v(0, 0, 0, 1, 2, 'h2A,   0, 0,     4,    6, 0, 0, 0,          0, 4, 'h22,  0, 0);
    vecs[14] = v(0, 0, 0, 0, 0, 0,      0, 0,     2,    6, 0, 1, 'h2A,       0, 5, 'h2A,  0, 0);
    vecs[15] = v(1, 9, 1, 0, 0, 0,      0, 0,     3,    6, 0, 1, 'h33,       1, 6, 'h33,  1, 'h100);
    vecs[16] = v(1, 10, 1, 1, 0, 'h55,  0, 0,     0,    0, 0, 0, 0,          0, 6, 'h33,  0, 'h100);
    vecs[17] = v(0, 0, 0, 0, 0, 0,      0, 0,     5,    0, 0, 0, 0,          0, 6, 'h33,  0, 'h100);
    vecs[18] = v(0, 0, 0, 0, 0, 0,      0, 0,     0,    0, 0, 0, 0,          0, 6, 'h33,  0, 'h100);

    #2;
    chk("reset we", 32'(bus.we), 32'd0);
    chk("reset waddr", 32'(bus.waddr), 32'd0);
    chk("reset wdata", bus.wdata, 32'd0);
    chk("reset rst_c", 32'(bus.rst_c), 32'd0);
    chk("reset full", 32'(bus.full), 32'd0);
    chk("reset alloc_id", 32'(bus.alloc_id), 32'd0);
    #10 rst = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      bus.alloc_en     = vecs[i].ae;
      bus.alloc_rd     = vecs[i].ard;
      bus.alloc_has_rd = vecs[i].ahr;
      bus.cdb_en       = vecs[i].ce;
      bus.cdb_id       = vecs[i].cid;
      bus.cdb_data     = vecs[i].cdata;
      bus.cdb_mispred  = vecs[i].cmp;
      bus.cdb_pc       = vecs[i].cpc;
      bus.qid1         = vecs[i].qid;
      bus.qid2         = vecs[i].qid;
      #1;
      chk($sformatf("v%0d alloc_id", i), 32'(bus.alloc_id), 32'(vecs[i].e_aid));
      chk($sformatf("v%0d full", i), 32'(bus.full), 32'(vecs[i].e_full));
      chk($sformatf("v%0d qrdy1", i), 32'(bus.qrdy1), 32'(vecs[i].e_qrdy));
      chk($sformatf("v%0d qrdy2", i), 32'(bus.qrdy2), 32'(vecs[i].e_qrdy));
      if (vecs[i].e_qrdy) begin
        chk($sformatf("v%0d qdata1", i), bus.qdata1, vecs[i].e_qdata);
        chk($sformatf("v%0d qdata2", i), bus.qdata2, vecs[i].e_qdata);
      end
      tick();
      chk($sformatf("v%0d we", i), 32'(bus.we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d waddr", i), 32'(bus.waddr), 32'(vecs[i].e_waddr));
      chk($sformatf("v%0d wdata", i), bus.wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d rst_c", i), 32'(bus.rst_c), 32'(vecs[i].e_rstc));
      chk($sformatf("v%0d flush_pc", i), bus.flush_pc, vecs[i].e_fpc);
    end
    idle();
    bus.qid1 = '0;
    bus.qid2 = '0;

    // Fill all 16 entries (entry k gets rd=k+1), then a refused 17th
    for (int i = 0; i < 16; i++) begin
      bus.alloc_en     = 1'b1;
      bus.alloc_rd     = 5'(i + 1);
      bus.alloc_has_rd = 1'b1;
      tick();
    end
    bus.alloc_en = 1'b0;
    #1;
    chk("fill full", 32'(bus.full), 32'd1);
    chk("fill alloc_id wrap", 32'(bus.alloc_id), 32'd0);
    bus.alloc_en = 1'b1;
    bus.alloc_rd = 5'd17;
    tick();
    bus.alloc_en = 1'b0;
    chk("17th full", 32'(bus.full), 32'd1);
    chk("17th alloc_id", 32'(bus.alloc_id), 32'd0);

    bus.cdb_en   = 1'b1;
    bus.cdb_id   = 5'd0;
    bus.cdb_data = 32'h77;
    tick();
    bus.cdb_en   = 1'b0;
    bus.alloc_en = 1'b1;
    bus.alloc_rd = 5'd20;
    #1;
    chk("retire-cycle full", 32'(bus.full), 32'd1);
    tick();
    chk("wrap we", 32'(bus.we), 32'd1);
    chk("wrap waddr", 32'(bus.waddr), 32'd1);
    chk("wrap wid", 32'(bus.wid), 32'd0);
    chk("wrap wdata", bus.wdata, 32'h77);
    bus.alloc_rd = 5'd21;
    #1;
    chk("after retire full", 32'(bus.full), 32'd0);
    chk("after retire alloc_id", 32'(bus.alloc_id), 32'd0);
    tick();
    bus.alloc_en = 1'b0;
    chk("realloc full", 32'(bus.full), 32'd1);
    chk("realloc alloc_id", 32'(bus.alloc_id), 32'd1);
    chk("realloc we", 32'(bus.we), 32'd0);

    // Stall with a retire pending on the write port
    bus.cdb_en   = 1'b1;
    bus.cdb_id   = 5'd1;
    bus.cdb_data = 32'h101;
    tick();
    bus.cdb_id   = 5'd2;
    bus.cdb_data = 32'h202;
    tick();
    bus.cdb_en   = 1'b0;
    rdy          = 1'b0;
    bus.alloc_en = 1'b1;
    bus.alloc_rd = 5'd22;
    chk("pre-stall we", 32'(bus.we), 32'd1);
    chk("pre-stall waddr", 32'(bus.waddr), 32'd2);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("stall%0d we", c), 32'(bus.we), 32'd1);
      chk($sformatf("stall%0d waddr", c), 32'(bus.waddr), 32'd2);
      chk($sformatf("stall%0d wid", c), 32'(bus.wid), 32'd1);
      chk($sformatf("stall%0d wdata", c), bus.wdata, 32'h101);
      chk($sformatf("stall%0d alloc_id", c), 32'(bus.alloc_id), 32'd1);
    end
    rdy          = 1'b1;
    bus.alloc_en = 1'b0;
    tick();
    chk("resume we", 32'(bus.we), 32'd1);
    chk("resume waddr", 32'(bus.waddr), 32'd3);
    chk("resume wid", 32'(bus.wid), 32'd2);
    chk("resume wdata", bus.wdata, 32'h202);
    tick();
    chk("resume idle we", 32'(bus.we), 32'd0);
    chk("resume alloc_id", 32'(bus.alloc_id), 32'd1);

    // Asynchronous reset mid-run while a write is being presented
    bus.cdb_en   = 1'b1;
    bus.cdb_id   = 5'd3;
    bus.cdb_data = 32'h303;
    tick();
    bus.cdb_en = 1'b0;
    tick();
    chk("pre-reset we", 32'(bus.we), 32'd1);
    chk("pre-reset waddr", 32'(bus.waddr), 32'd4);
    #2 rst = 1'b1;
    #1;
    chk("midreset we", 32'(bus.we), 32'd0);
    chk("midreset rst_c", 32'(bus.rst_c), 32'd0);
    chk("midreset full", 32'(bus.full), 32'd0);
    chk("midreset alloc_id", 32'(bus.alloc_id), 32'd0);
    chk("midreset waddr", 32'(bus.waddr), 32'd0);
    chk("midreset wdata", bus.wdata, 32'd0);
    chk("midreset flush_pc", bus.flush_pc, 32'd0);
    #3 rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
